// File: rtl/evr_pkg.sv
// Shared event codes, widths and shift-counter limits for the event receiver decoder.
// Optional build macro used by the decoder: EVR_TS_INTERNAL_EN.
package evr_pkg;

    localparam int EVT_W = 8;
    localparam int TS_W  = 32;

    localparam logic [EVT_W-1:0] EVT_NULL      = 8'h00;
    localparam logic [EVT_W-1:0] EVT_SEC0      = 8'h70;
    localparam logic [EVT_W-1:0] EVT_SEC1      = 8'h71;
    localparam logic [EVT_W-1:0] EVT_HEARTBEAT = 8'h7A;
    localparam logic [EVT_W-1:0] EVT_TS_TICK   = 8'h7C;
    localparam logic [EVT_W-1:0] EVT_TS_RESET  = 8'h7D;
    localparam logic [EVT_W-1:0] K28_5         = 8'hBC;

    // A seconds load is only trusted when exactly TS_W bits were shifted in.
    localparam logic [5:0] SHIFT_FULL = 6'd32;
    localparam logic [5:0] SHIFT_SAT  = 6'd33;

endpackage

// File: rtl/evr_heartbeat_monitor.sv
// Heartbeat supervision: flags heartbeatLost after HB_TIMEOUT cycles without a heartbeat event.
// Latency: flag registered on the edge the count reaches HB_TIMEOUT-1; no backpressure.
module evr_heartbeat_monitor #(
    parameter logic [31:0] HB_TIMEOUT = 32'd200_000_000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic heartbeat,
    output logic heartbeatLost
);

    logic [31:0] hbCnt;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            hbCnt         <= 32'd0;
            heartbeatLost <= 1'b0;
        end else if (HB_TIMEOUT == 32'd0) begin
            hbCnt         <= 32'd0;
            heartbeatLost <= 1'b0;
        end else if (heartbeat) begin
            // A heartbeat on the timeout edge takes priority over raising the flag.
            hbCnt         <= 32'd0;
            heartbeatLost <= 1'b0;
        end else begin
            if (hbCnt != HB_TIMEOUT)
                hbCnt <= hbCnt + 32'd1;
            if (hbCnt == HB_TIMEOUT - 32'd1)
                heartbeatLost <= 1'b1;
        end
    end

endmodule

// File: rtl/evr_event_decoder.sv
// Event receiver decoder: qualifies received event codes, tracks timestamp, counts K-code errors.
// Latency 1 cycle rxData -> eventStream/dBus; no backpressure. Macro EVR_TS_INTERNAL_EN: free-running subSeconds.
module evr_event_decoder
    import evr_pkg::*;
#(
    parameter logic [31:0] HB_TIMEOUT = 32'd200_000_000
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [15:0]       rxData,
    input  logic [1:0]        rxCharIsK,
    input  logic              rxLinkOk,
    output logic [EVT_W-1:0]  eventStream,
    output logic [EVT_W-1:0]  dBus,
    output logic [TS_W-1:0]   seconds,
    output logic [TS_W-1:0]   subSeconds,
    output logic              tsValid,
    output logic              heartbeatLost,
    output logic [15:0]       codeErrCount
);

    logic [EVT_W-1:0] rxCode;
    logic             evtQual;
    logic             codeErr;
    logic             isShift;
    logic             isTsReset;
    logic             isHeartbeat;
    logic [TS_W-1:0]  shiftReg;
    logic [5:0]       shiftCnt;

    always_comb begin
        rxCode      = rxData[EVT_W-1:0];
        evtQual     = rxLinkOk && !rxCharIsK[0];
        codeErr     = rxLinkOk && rxCharIsK[0] && (rxCode != K28_5);
        isShift     = evtQual && ((rxCode == EVT_SEC0) || (rxCode == EVT_SEC1));
        isTsReset   = evtQual && (rxCode == EVT_TS_RESET);
        isHeartbeat = evtQual && (rxCode == EVT_HEARTBEAT);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            eventStream  <= EVT_NULL;
            dBus         <= '0;
            seconds      <= '0;
            subSeconds   <= '0;
            tsValid      <= 1'b0;
            codeErrCount <= 16'd0;
            shiftReg     <= '0;
            shiftCnt     <= 6'd0;
        end else begin
            eventStream <= evtQual ? rxCode : EVT_NULL;

            if (rxLinkOk && !rxCharIsK[1])
                dBus <= rxData[15:8];

            if (codeErr && (codeErrCount != 16'hFFFF))
                codeErrCount <= codeErrCount + 16'd1;

            // Losing the link invalidates any seconds value being assembled.
            if (!rxLinkOk) begin
                tsValid  <= 1'b0;
                shiftCnt <= 6'd0;
            end else if (isShift) begin
                shiftReg <= {shiftReg[TS_W-2:0], rxCode[0]};
                if (shiftCnt != SHIFT_SAT)
                    shiftCnt <= shiftCnt + 6'd1;
            end else if (isTsReset) begin
                seconds  <= shiftReg;
                tsValid  <= (shiftCnt == SHIFT_FULL);
                shiftCnt <= 6'd0;
            end

`ifdef EVR_TS_INTERNAL_EN
            if (isTsReset)
                subSeconds <= '0;
            else
                subSeconds <= subSeconds + 32'd1;
`else
            if (isTsReset)
                subSeconds <= '0;
            else if (evtQual && (rxCode == EVT_TS_TICK))
                subSeconds <= subSeconds + 32'd1;
`endif
        end
    end

    evr_heartbeat_monitor #(
        .HB_TIMEOUT(HB_TIMEOUT)
    ) u_hbMon (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .heartbeat    (isHeartbeat),
        .heartbeatLost(heartbeatLost)
    );

endmodule

// File: tb/tb_evr_event_decoder.sv
// Directed bench for evr_event_decoder: driver queues hand-computed expectations, monitor compares after each edge.
module tb_evr_event_decoder;

    localparam logic [6:0] M_EV  = 7'h01;
    localparam logic [6:0] M_DB  = 7'h02;
    localparam logic [6:0] M_SEC = 7'h04;
    localparam logic [6:0] M_SUB = 7'h08;
    localparam logic [6:0] M_TSV = 7'h10;
    localparam logic [6:0] M_HBL = 7'h20;
    localparam logic [6:0] M_CEC = 7'h40;

    typedef struct {
        string       tag;
        logic [6:0]  m;
        logic [7:0]  ev;
        logic [7:0]  db;
        logic [31:0] sec;
        logic [31:0] sub;
        logic        tsv;
        logic        hbl;
        logic [15:0] cec;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [15:0] rxData;
    logic [1:0]  rxCharIsK;
    logic        rxLinkOk;
    logic [7:0]  eventStream;
    logic [7:0]  dBus;
    logic [31:0] seconds;
    logic [31:0] subSeconds;
    logic        tsValid;
    logic        heartbeatLost;
    logic [15:0] codeErrCount;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic [6:0] subHoldMask;

    always #5 Clock = ~Clock;

    evr_event_decoder #(.HB_TIMEOUT(32'd10)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .rxData       (rxData),
        .rxCharIsK    (rxCharIsK),
        .rxLinkOk     (rxLinkOk),
        .eventStream  (eventStream),
        .dBus         (dBus),
        .seconds      (seconds),
        .subSeconds   (subSeconds),
        .tsValid      (tsValid),
        .heartbeatLost(heartbeatLost),
        .codeErrCount (codeErrCount)
    );

    task automatic chk(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", tag, field, act, exp);
        end
    endtask

    // Monitor: one expectation per clock edge, compared 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.m & M_EV)  chk(e.tag, "eventStream",   32'(eventStream),   32'(e.ev));
                if (e.m & M_DB)  chk(e.tag, "dBus",          32'(dBus),          32'(e.db));
                if (e.m & M_SEC) chk(e.tag, "seconds",       seconds,            e.sec);
                if (e.m & M_SUB) chk(e.tag, "subSeconds",    subSeconds,         e.sub);
                if (e.m & M_TSV) chk(e.tag, "tsValid",       32'(tsValid),       32'(e.tsv));
                if (e.m & M_HBL) chk(e.tag, "heartbeatLost", 32'(heartbeatLost), 32'(e.hbl));
                if (e.m & M_CEC) chk(e.tag, "codeErrCount",  32'(codeErrCount),  32'(e.cec));
            end
        end
    end

    task automatic step(input logic [15:0] d, input logic [1:0] k, input logic l, input string tag,
                        input logic [6:0] m, input logic [7:0] ev, input logic [7:0] db,
                        input logic [31:0] sec, input logic [31:0] sub, input logic tsv,
                        input logic hbl, input logic [15:0] cec);
        exp_t e;
        rxData    = d;
        rxCharIsK = k;
        rxLinkOk  = l;
        e.tag = tag; e.m = m; e.ev = ev; e.db = db; e.sec = sec;
        e.sub = sub; e.tsv = tsv; e.hbl = hbl; e.cec = cec;
        q.push_back(e);
        @(negedge Clock);
    endtask

    task automatic idle(input logic [15:0] d, input logic [1:0] k, input logic l);
        step(d, k, l, "idle", 7'h00, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
    endtask

    // Shift the low n bits of w, MSB first, as seconds-bit events.
    task automatic shiftBits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--)
            idle(w[i] ? 16'h0071 : 16'h0070, 2'b00, 1'b1);
    endtask

    initial begin
`ifdef EVR_TS_INTERNAL_EN
        subHoldMask = 7'h00;
`else
        subHoldMask = M_SUB;
`endif
        Reset_n = 1'b0;
        idle(16'h5A21, 2'b00, 1'b1);
        idle(16'h5A21, 2'b00, 1'b1);
        step(16'h5A21, 2'b00, 1'b1, "reset", 7'h7F, 8'h00, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
        Reset_n = 1'b1;

        // Plain event forwarding and K28.5 idle.
        step(16'h5A21, 2'b00, 1'b1, "evt", M_EV | M_DB | M_HBL | M_CEC, 8'h21, 8'h5A, 0, 0, 0, 1'b0, 16'h0);
        step(16'h5ABC, 2'b01, 1'b1, "k285", M_EV | M_DB | M_CEC, 8'h00, 8'h5A, 0, 0, 0, 0, 16'h0);

        // Heartbeat timeout of 10: flag rises on the 10th edge after reset.
        for (int i = 3; i <= 8; i++) idle(16'h0000, 2'b00, 1'b1);
        step(16'h0000, 2'b00, 1'b1, "hb_pre", M_HBL, 0, 0, 0, 0, 0, 1'b0, 0);
        step(16'h0000, 2'b00, 1'b1, "hb_lost", M_HBL | M_EV, 8'h00, 0, 0, 0, 0, 1'b1, 0);
        step(16'h007A, 2'b00, 1'b1, "hb_clear", M_HBL | M_EV, 8'h7A, 0, 0, 0, 0, 1'b0, 0);
        for (int i = 12; i <= 19; i++) idle(16'h0000, 2'b00, 1'b1);
        step(16'h0000, 2'b00, 1'b1, "hb_cnt9", M_HBL, 0, 0, 0, 0, 0, 1'b0, 0);
        step(16'h007A, 2'b00, 1'b1, "hb_race", M_HBL | M_EV, 8'h7A, 0, 0, 0, 0, 1'b0, 0);
        step(16'h0000, 2'b00, 1'b1, "hb_after", M_HBL, 0, 0, 0, 0, 0, 1'b0, 0);

        // Full 32-bit seconds load.
        shiftBits(32'h5F5E_1000, 32);
        step(16'h007D, 2'b00, 1'b1, "ts32", M_EV | M_SEC | M_SUB | M_TSV, 8'h7D, 0, 32'h5F5E_1000, 32'h0, 1'b1, 0, 0);

        // Link loss mid-shift: events suppressed, no error count, shift restarts.
        shiftBits(32'h0000_03FF, 10);
        step(16'h00F7, 2'b01, 1'b0, "linkdown", M_EV | M_TSV | M_SEC | M_CEC | subHoldMask,
             8'h00, 0, 32'h5F5E_1000, 32'h0, 1'b0, 0, 16'h0);
        shiftBits(32'h0, 22);
        step(16'h007D, 2'b00, 1'b1, "ts_relink", M_TSV, 8'h7D, 0, 0, 0, 1'b0, 0, 0);

        // Only 31 bits shifted: value loads but is not valid.
        shiftBits(32'h1234_5678, 31);
        step(16'h007D, 2'b00, 1'b1, "ts31", M_SEC | M_SUB | M_TSV, 0, 0, 32'h1234_5678, 32'h0, 1'b0, 0, 0);

        // Sub-second ticks and wrap.
        for (int i = 0; i < 4; i++) idle(16'h007C, 2'b00, 1'b1);
        step(16'h007C, 2'b00, 1'b1, "tick5", M_SUB | M_SEC | M_EV, 8'h7C, 0, 32'h1234_5678, 32'd5, 0, 0, 0);
        force dut.subSeconds = 32'hFFFF_FFFF;
        #1;
        release dut.subSeconds;
        step(16'h007C, 2'b00, 1'b1, "wrap", M_SUB | M_SEC, 0, 0, 32'h1234_5678, 32'h0, 0, 0, 0);

        // Non-K28.5 K-codes on the event byte.
        step(16'h00F7, 2'b01, 1'b1, "kerr1", M_EV | M_CEC, 8'h00, 0, 0, 0, 0, 0, 16'd1);
        step(16'h00F7, 2'b01, 1'b1, "kerr2", M_EV | M_CEC, 8'h00, 0, 0, 0, 0, 0, 16'd2);
        step(16'h00F7, 2'b01, 1'b1, "kerr3", M_EV | M_CEC, 8'h00, 0, 0, 0, 0, 0, 16'd3);

        // K flag on the bus byte holds dBus but still forwards the event.
        step(16'hAB33, 2'b00, 1'b1, "dbus", M_EV | M_DB, 8'h33, 8'hAB, 0, 0, 0, 0, 0);
        step(16'hFC44, 2'b10, 1'b1, "dbus_k", M_EV | M_DB | M_CEC, 8'h44, 8'hAB, 0, 0, 0, 0, 16'd3);

`ifdef EVR_TS_INTERNAL_EN
        // Free-running sub-seconds; interleaved ticks add nothing.
        step(16'h007D, 2'b00, 1'b1, "int_rst", M_SUB | M_EV, 8'h7D, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            if (i == 50 || i == 100)
                step(16'h0000, 2'b00, 1'b1, "int_sub", M_SUB, 0, 0, 0, 32'(i), 0, 0, 0);
            else
                idle((i % 10 == 3) ? 16'h007C : 16'h0000, 2'b00, 1'b1);
        end
`endif

        idle(16'h0000, 2'b00, 1'b1);
        @(negedge Clock);
        chk("end", "queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/evr_event_decoder.md
Name: evr_event_decoder

Overview:
- Sits directly upstream of the per-channel trigger generators.
- Takes the 16-bit word from the GTX receiver after 8b/10b decode: low byte is the event code, high byte is the distributed bus.
- Produces the registered one-cycle event code stream that every trigger channel compares against its programmed event.
- Also maintains the seconds/sub-second timestamp and heartbeat supervision from the special event codes.

Parameters:
- HB_TIMEOUT, 32'd200_000_000: Clock cycles without heartbeat event before heartbeatLost asserts; 0 disables supervision.

Ports:
- Clock  in  1  recovered event clock; all logic on rising edge
- Reset_n  in  1  synchronous reset, active-low
- rxData  in  16  [7:0] event code, [15:8] distributed bus byte
- rxCharIsK  in  2  per-byte K-character flag, bit0 for [7:0]
- rxLinkOk  in  1  receiver aligned and in sync
- eventStream  out  8  registered event code; 8'h00 when no event
- dBus  out  8  registered distributed bus byte
- seconds  out  32  timestamp seconds
- subSeconds  out  32  timestamp sub-second ticks
- tsValid  out  1  seconds field loaded from a complete 32-bit shift
- heartbeatLost  out  1  heartbeat timeout flag
- codeErrCount  out  16  count of K-characters on the event byte other than K28.5, saturating

Behaviour:
- Reset (Reset_n=0 at edge): all outputs and internal registers 0. Reset mid-operation discards a partially shifted seconds value.
- Latency: eventStream and dBus update 1 cycle after rxData is sampled.
- Event qualification: eventStream <= rxData[7:0] only when rxLinkOk=1 and rxCharIsK[0]=0; otherwise 8'h00.
  - K28.5 (8'hBC with K flag) yields 8'h00 and is not an error.
  - Any other K on the event byte yields 8'h00 and increments codeErrCount when rxLinkOk=1; the count saturates at 16'hFFFF.
- dBus <= rxData[15:8] when rxLinkOk=1 and rxCharIsK[1]=0; otherwise it holds its previous value.
- Special codes act on the same edge the qualified code is registered; all codes, special ones included, are still forwarded on eventStream.
- 8'h70 / 8'h71 (seconds bit 0 / 1):
  - shiftReg <= {shiftReg[30:0], bit}.
  - shiftCnt increments, saturating at 33 (6-bit).
- 8'h7D (timestamp reset):
  - seconds <= shiftReg; subSeconds <= 0.
  - tsValid <= (shiftCnt == 32).
  - shiftCnt <= 0; shiftReg retains its value.
- 8'h7C (tick): subSeconds <= subSeconds + 1, wrapping 32'hFFFFFFFF -> 0; seconds is unaffected by the wrap.
- 8'h7A (heartbeat): hbCnt <= 0; heartbeatLost <= 0.
- Heartbeat supervision:
  - Otherwise hbCnt increments each cycle, saturating at HB_TIMEOUT.
  - heartbeatLost <= 1 when hbCnt reaches HB_TIMEOUT-1.
  - A heartbeat in the same cycle as the timeout wins: the flag stays 0.
- Link loss:
  - rxLinkOk=0 clears tsValid and shiftCnt; seconds and subSeconds hold.
  - The heartbeat counter keeps running through link loss.
- Only one event per cycle, so no conflicts exist between special codes.

Optional Feature:
- Macro EVR_TS_INTERNAL_EN.
- Defined: subSeconds increments every Clock cycle, and 8'h7C is ignored for timestamping (still forwarded). The wrap rule and reset by 8'h7D are unchanged.
- Undefined: subSeconds advances only on 8'h7C, as specified above.

Decomposition:
- Package evr_pkg:
  - EVT_NULL=8'h00, EVT_SEC0=8'h70, EVT_SEC1=8'h71, EVT_HEARTBEAT=8'h7A, EVT_TS_TICK=8'h7C, EVT_TS_RESET=8'h7D, K28_5=8'hBC.
  - Widths EVT_W=8, TS_W=32.
- One sub-module: evr_heartbeat_monitor (hbCnt, timeout compare, heartbeatLost), parameterised by HB_TIMEOUT.
- Timestamp and shift logic stay in the top.

Test Plan:
- Reset held 3 cycles, then rxData=16'h5A21, rxCharIsK=0, rxLinkOk=1 -> next cycle eventStream=8'h21, dBus=8'h5A; one cycle later with rxData=16'h5ABC, rxCharIsK=2'b01 -> eventStream=8'h00, codeErrCount=0.
- Shift 32 bits encoding 32'h5F5E_1000 MSB first via 8'h70/8'h71, then 8'h7D -> seconds=32'h5F5E1000, subSeconds=0, tsValid=1; repeat with only 31 bits -> tsValid=0.
- After 8'h7D, send five 8'h7C -> subSeconds=5; preload subSeconds=32'hFFFFFFFF and send 8'h7C -> subSeconds=0, seconds unchanged.
- HB_TIMEOUT=10, no 8'h7A -> heartbeatLost=1 on the 10th cycle; 8'h7A arriving exactly on that cycle -> heartbeatLost stays 0.
- K-code 8'hF7 on the event byte with rxLinkOk=1, 3 times -> codeErrCount=3, eventStream=0; drop rxLinkOk mid-shift -> tsValid=0, shiftCnt=0, events forced to 0.
- With EVR_TS_INTERNAL_EN defined: 8'h7D followed by 100 idle cycles -> subSeconds=100; interleaved 8'h7C has no extra effect.
